// File: rtl/simd_booth_pkg.sv
// Shared constants, FSM state type and lane layout offsets for the SIMD Booth sequencer.
package simd_booth_pkg;

    localparam logic [1:0] MODE_1X16 = 2'b00;
    localparam logic [1:0] MODE_2X8  = 2'b01;
    localparam logic [1:0] MODE_4X4  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int unsigned ITER_1X16 = 16;
    localparam int unsigned ITER_2X8  = 8;
    localparam int unsigned ITER_4X4  = 4;
    localparam int unsigned CNT_W     = 4;

    // Accumulator store field offsets; each lane is packed {A, Q, Qm1}
    localparam int unsigned L1X16_A_W   = 19;
    localparam int unsigned L2X8_L1_LSB = 17;
    localparam int unsigned L2X8_L0_A_W = 8;
    localparam int unsigned L2X8_L1_A_W = 10;
    localparam int unsigned L4X4_STRIDE = 9;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_e;

    function automatic logic [CNT_W-1:0] iter_last(input logic [1:0] m);
        case (m)
            MODE_2X8: return CNT_W'(ITER_2X8 - 1);
            MODE_4X4: return CNT_W'(ITER_4X4 - 1);
            default:  return CNT_W'(ITER_1X16 - 1);
        endcase
    endfunction

endpackage

// File: rtl/simd_booth_lane_step.sv
// One radix-2 Booth step for a single lane {A, Q, Qm1}: conditional add/sub of the
// sign-extended multiplicand into A, then an arithmetic right shift of the whole lane.
module booth_lane_step #(
    parameter int A_W = 19,
    parameter int Q_W = 16
) (
    input  logic [A_W+Q_W:0] lane_i,
    input  logic [Q_W-1:0]   m_i,
    output logic [A_W+Q_W:0] lane_o
);

    logic [A_W-1:0] a;
    logic [A_W-1:0] ms;
    logic [A_W-1:0] a_sum;
    logic [Q_W-1:0] q;
    logic           qm1;

    assign a   = lane_i[A_W+Q_W:Q_W+1];
    assign q   = lane_i[Q_W:1];
    assign qm1 = lane_i[0];
    assign ms  = A_W'($signed(m_i));

    always_comb begin
        a_sum = a;
        case ({q[0], qm1})
            2'b01:   a_sum = a + ms;
            2'b10:   a_sum = a - ms;
            default: a_sum = a;
        endcase
    end

    // Old Qm1 falls off the bottom; Q[0] becomes the new Qm1
    assign lane_o = {a_sum[A_W-1], a_sum, q};

endmodule

// File: rtl/simd_booth_seq_ctrl.sv
// Sequencer and per-lane Booth step datapath wrapped around the external accumulator store.
// Optional operand check enabled by defining BOOTH_OPCHECK_EN.
module simd_booth_seq_ctrl
    import simd_booth_pkg::*;
#(
    parameter int ACC_W  = 36,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   mcand,
    input  logic [DATA_W-1:0]   mplier,
    input  logic [ACC_W-1:0]    acc_q,
    output logic [ACC_W-1:0]    acc_d,
    output logic [DATA_W-1:0]   acc_q_init,
    output logic                acc_clr,
    output logic                acc_ld,
    output logic [1:0]          mode_o,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product,
    output logic [3:0]          illegal_lanes
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0]  mplier_q, mplier_d;
    logic               start_ok;

    assign start_ok = start && (mode != MODE_RSVD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mode_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mode_d   = mode_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mode_d   = mode;
                    mcand_d  = mcand;
                    mplier_d = mplier;
                    state_d  = INIT;
                end
            end
            INIT: begin
                count_d = iter_last(mode_q);
                state_d = RUN;
            end
            RUN: begin
                if (count_q == '0) state_d = DONE;
                else               count_d = count_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign acc_clr    = (state_q == INIT);
    assign acc_ld     = (state_q == RUN);
    assign acc_q_init = mplier_q;
    assign mode_o     = mode_q;

    logic [ACC_W-1:0]          step_1x16;
    logic [L2X8_L1_LSB-1:0]    step_2x8_l0;
    logic [ACC_W-L2X8_L1_LSB-1:0] step_2x8_l1;
    logic [ACC_W-1:0]          step_4x4;
    logic [2*DATA_W-1:0]       prod_4x4;

    booth_lane_step #(.A_W(L1X16_A_W), .Q_W(16)) u_step_1x16 (
        .lane_i (acc_q),
        .m_i    (mcand_q),
        .lane_o (step_1x16)
    );

    booth_lane_step #(.A_W(L2X8_L0_A_W), .Q_W(8)) u_step_2x8_l0 (
        .lane_i (acc_q[L2X8_L1_LSB-1:0]),
        .m_i    (mcand_q[7:0]),
        .lane_o (step_2x8_l0)
    );

    booth_lane_step #(.A_W(L2X8_L1_A_W), .Q_W(8)) u_step_2x8_l1 (
        .lane_i (acc_q[ACC_W-1:L2X8_L1_LSB]),
        .m_i    (mcand_q[15:8]),
        .lane_o (step_2x8_l1)
    );

    for (genvar i = 0; i < 4; i++) begin : g_4x4
        booth_lane_step #(.A_W(4), .Q_W(4)) u_step (
            .lane_i (acc_q[L4X4_STRIDE*i +: L4X4_STRIDE]),
            .m_i    (mcand_q[4*i +: 4]),
            .lane_o (step_4x4[L4X4_STRIDE*i +: L4X4_STRIDE])
        );
        assign prod_4x4[8*i +: 8] = acc_q[L4X4_STRIDE*i+1 +: 8];
    end

    always_comb begin
        acc_d   = step_1x16;
        product = acc_q[32:1];
        case (mode_q)
            MODE_2X8: begin
                acc_d   = {step_2x8_l1, step_2x8_l0};
                product = {acc_q[L2X8_L1_LSB+16:L2X8_L1_LSB+1], acc_q[16:1]};
            end
            MODE_4X4: begin
                acc_d   = step_4x4;
                product = prod_4x4;
            end
            default: ;
        endcase
    end

`ifdef BOOTH_OPCHECK_EN
    logic [3:0] ill_q, ill_d;

    // Flags lanes whose A field is only lane-wide and cannot hold -(most negative)
    always_comb begin
        ill_d = ill_q;
        if (state_q == IDLE && start_ok) begin
            ill_d = '0;
        end else if (state_q == INIT) begin
            ill_d = '0;
            case (mode_q)
                MODE_2X8: ill_d[0] = (mcand_q[7:0] == 8'h80);
                MODE_4X4: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        ill_d[i] = (mcand_q[4*i +: 4] == 4'h8);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ill_q <= '0;
        else     ill_q <= ill_d;
    end

    assign illegal_lanes = ill_q;
`else
    assign illegal_lanes = '0;
`endif

endmodule

// File: tb/tb_simd_booth_seq_ctrl.sv
// Directed self-checking bench for simd_booth_seq_ctrl with a behavioural accumulator store.
module tb_simd_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [35:0] acc_q;
    logic [35:0] acc_d;
    logic [15:0] acc_q_init;
    logic        acc_clr;
    logic        acc_ld;
    logic [1:0]  mode_o;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [3:0]  illegal_lanes;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BOOTH_OPCHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    simd_booth_seq_ctrl #(.ACC_W(36), .DATA_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .mcand         (mcand),
        .mplier        (mplier),
        .acc_q         (acc_q),
        .acc_d         (acc_d),
        .acc_q_init    (acc_q_init),
        .acc_clr       (acc_clr),
        .acc_ld        (acc_ld),
        .mode_o        (mode_o),
        .busy          (busy),
        .done          (done),
        .product       (product),
        .illegal_lanes (illegal_lanes)
    );

    // Accumulator store: clear places the multiplier in each lane's Q field, A and Qm1 zero
    function automatic logic [35:0] store_init(input logic [15:0] q, input logic [1:0] m);
        logic [35:0] v;
        v = '0;
        case (m)
            2'b01: begin
                v[25:18] = q[15:8];
                v[8:1]   = q[7:0];
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) v[9*i+1 +: 4] = q[4*i +: 4];
            end
            default: v[16:1] = q;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (acc_clr)     acc_q <= store_init(acc_q_init, mode_o);
        else if (acc_ld) acc_q <= acc_d;
    end

    task automatic run_mult(input string name, input logic [1:0] md, input logic [15:0] mc,
                            input logic [15:0] mp, input logic [31:0] exp_prod,
                            input bit chk_prod, input logic [3:0] exp_ill);
        int k;
        int n_exp;
        bit seen;
        n_exp = (md == 2'b00) ? 17 : (md == 2'b01) ? 9 : 5;
        @(negedge clk);
        start = 1'b1; mode = md; mcand = mc; mplier = mp;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (acc_clr !== 1'b1 || busy !== 1'b1 || acc_ld !== 1'b0) begin
            n_bad++;
            $display("FAIL %s init strobes: acc_clr=%b busy=%b acc_ld=%b, required 1 1 0", name, acc_clr, busy, acc_ld);
        end
        n_cmp++;
        if (acc_q_init !== mp || mode_o !== md) begin
            n_bad++;
            $display("FAIL %s latch: acc_q_init=%h mode_o=%b, required %h %b", name, acc_q_init, mode_o, mp, md);
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                n_cmp++;
                if (illegal_lanes !== exp_ill) begin
                    n_bad++;
                    $display("FAIL %s illegal_lanes: got %h, required %h", name, illegal_lanes, exp_ill);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (acc_ld !== 1'b1 || acc_clr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s run strobes: acc_ld=%b acc_clr=%b, required 1 0", name, acc_ld, acc_clr);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || k != n_exp || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s latency: done after %0d edges (seen=%b busy=%b), required %0d", name, k, seen, busy, n_exp);
        end
        if (chk_prod) begin
            n_cmp++;
            if (product !== exp_prod) begin
                n_bad++;
                $display("FAIL %s product: got %h, required %h", name, product, exp_prod);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after done: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; mcand = '0; mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || acc_clr !== 1'b0 || acc_ld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset strobes: busy=%b done=%b clr=%b ld=%b, required 0 0 0 0", busy, done, acc_clr, acc_ld);
        end
        n_cmp++;
        if (mode_o !== 2'b00 || acc_q_init !== 16'h0000 || illegal_lanes !== 4'h0) begin
            n_bad++;
            $display("FAIL reset latches: mode_o=%b acc_q_init=%h ill=%h, required 00 0000 0", mode_o, acc_q_init, illegal_lanes);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode_1x16();
        run_mult("1x16_7xm3", 2'b00, 16'h0007, 16'hFFFD, 32'hFFFFFFEB, 1'b1, 4'h0);
        run_mult("1x16_minxmin", 2'b00, 16'h8000, 16'h8000, 32'h40000000, 1'b1, 4'h0);
    endtask

    task automatic test_mode_2x8();
        run_mult("2x8", 2'b01, 16'hFD05, 16'h0AF9, 32'hFFE2FFDD, 1'b1, 4'h0);
    endtask

    task automatic test_mode_4x4();
        run_mult("4x4", 2'b10, 16'h7F32, 16'h2F37, 32'h0E01090E, 1'b1, 4'h0);
    endtask

    task automatic test_start_ignored();
        int k;
        int pulses;
        int first_k;
        logic [31:0] prod_seen;
        @(negedge clk);
        start = 1'b1; mode = 2'b11; mcand = 16'h1234; mplier = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || acc_clr !== 1'b0) begin
            n_bad++;
            $display("FAIL rsvd_mode start: busy=%b acc_clr=%b, required 0 0", busy, acc_clr);
        end
        @(negedge clk);
        start = 1'b1; mode = 2'b10; mcand = 16'h7F32; mplier = 16'h2F37;
        @(posedge clk); #1;
        mode = 2'b00; mcand = 16'hFFFF; mplier = 16'hFFFF;
        k = 0; pulses = 0; first_k = 0; prod_seen = '0;
        repeat (16) begin
            @(posedge clk); #1;
            k++;
            if (k <= 4) begin
                n_cmp++;
                if (mode_o !== 2'b10 || busy !== 1'b1 || acc_q_init !== 16'h2F37) begin
                    n_bad++;
                    $display("FAIL busy_start edge %0d: mode_o=%b busy=%b acc_q_init=%h, required 10 1 2f37", k, mode_o, busy, acc_q_init);
                end
            end
            if (k == 4) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_k == 0) begin
                    first_k = k;
                    prod_seen = product;
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || first_k != 5) begin
            n_bad++;
            $display("FAIL busy_start done: %0d pulses first at edge %0d, required 1 at 5", pulses, first_k);
        end
        n_cmp++;
        if (prod_seen !== 32'h0E01090E || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start result: product=%h busy=%b, required 0e01090e 0", prod_seen, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        start = 1'b1; mode = 2'b00; mcand = 16'h0007; mplier = 16'hFFFD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (acc_ld !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun pre-reset: acc_ld=%b, required 1", acc_ld);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || acc_ld !== 1'b0 || acc_clr !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun reset: busy=%b ld=%b clr=%b done=%b, required 0 0 0 0", busy, acc_ld, acc_clr, done);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL midrun idle: %0d active cycles after reset, required 0", pulses);
        end
        run_mult("after_rst", 2'b00, 16'h0007, 16'hFFFD, 32'hFFFFFFEB, 1'b1, 4'h0);
    endtask

    task automatic test_opcheck();
        logic [3:0] exp4;
        logic [3:0] exp1;
        exp4 = OPCHK ? 4'hF : 4'h0;
        exp1 = OPCHK ? 4'h1 : 4'h0;
        run_mult("opcheck_4x4", 2'b10, 16'h8888, 16'h1111, 32'h0, 1'b0, exp4);
        n_cmp++;
        if (illegal_lanes !== exp4) begin
            n_bad++;
            $display("FAIL opcheck hold: got %h, required %h", illegal_lanes, exp4);
        end
        run_mult("opcheck_2x8", 2'b01, 16'h8080, 16'h0101, 32'h0, 1'b0, exp1);
        run_mult("opcheck_1x16", 2'b00, 16'h8888, 16'h0001, 32'hFFFF8888, 1'b1, 4'h0);
    endtask

    initial begin
        test_reset();
        test_mode_1x16();
        test_mode_2x8();
        test_mode_4x4();
        test_start_ignored();
        test_reset_mid_run();
        test_opcheck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simd_booth_seq_ctrl.md
Name: simd_booth_seq_ctrl

Overview:
Sequencer and Booth radix-2 step datapath for the SIMD Booth multiplier. It sits directly around the accumulator store:
- drives the store's Q, clr, ld and in ports;
- reads back the store's out bus;
- performs one Booth add/sub plus arithmetic-shift step per cycle on every lane of the selected mode, then presents packed products with a done pulse.

Parameters:
ACC_W, 36, accumulator store width (fixed layout; other values unsupported)
DATA_W, 16, total operand width across lanes

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled in IDLE only
mode  in  2  00=1x16, 01=2x8, 10=4x4, 11=reserved
mcand  in  16  multiplicand(s), lane i in nibble/byte i
mplier  in  16  multiplier(s), same lane packing
acc_q  in  36  accumulator store out bus
acc_d  out  36  next accumulator value, to store in
acc_q_init  out  16  multiplier value, to store Q
acc_clr  out  1  store clear/init strobe
acc_ld  out  1  store load strobe
mode_o  out  2  latched mode, to store mode
busy  out  1  high from accepted start to DONE inclusive
done  out  1  one-cycle pulse in DONE
product  out  32  packed signed products, valid while done=1
illegal_lanes  out  4  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, acc_clr=0, acc_ld=0, count=0, latched mode/mcand/mplier=0, illegal_lanes=0. acc_d and product are combinational from acc_q.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE: on start=1 and mode!=11, latch mode, mcand and mplier, then go to INIT. Start with mode=11 is ignored.
- INIT: one cycle. acc_clr=1, acc_q_init=latched mplier, count=N-1, where N=16/8/4 for modes 00/01/10. Next state RUN.
- RUN: acc_ld=1 and acc_d=step(acc_q) every cycle. Decrement count; when count==0, go to DONE.
- DONE: one cycle. done=1, product extracted from acc_q. Next state IDLE.
- Latency: start accepted at edge t; done is high in cycle t+N+2.
- start while busy is ignored. rst in any state forces IDLE on the next edge; strobes drop immediately.
- Lane layout, field order {A, Q, Qm1}:
  - mode 00: A=[35:17] (19b), Q=[16:1], Qm1=[0].
  - mode 01, lane0: A=[16:9], Q=[8:1], Qm1=[0].
  - mode 01, lane1: A=[35:26] (10b), Q=[25:18], Qm1=[17].
  - mode 10, lane i: A=[9i+8:9i+5], Q=[9i+4:9i+1], Qm1=[9i].
- Step per lane:
  - {Q0,Qm1}=01: A=A+Ms. {Q0,Qm1}=10: A=A-Ms. Otherwise A unchanged.
  - Ms is the lane multiplicand sign-extended to the A width; arithmetic is modulo the A width.
  - Then arithmetic right shift of the whole lane by 1, replicating the new A MSB.
  - No carry or shift crosses lane boundaries.
- Product packing:
  - mode 00: product=acc_q[32:1].
  - mode 01: product={acc_q[33:18], acc_q[16:1]}.
  - mode 10: product={p3,p2,p1,p0}, pi=acc_q[9i+8:9i+1].
- Operand restriction: lanes with an A field equal to the lane width (mode 01 lane0, all mode 10 lanes) give an undefined result for multiplicand = most negative value.

Optional Feature:
BOOTH_OPCHECK_EN
- Defined: in INIT, illegal_lanes[i] is set for each restricted lane whose latched multiplicand equals the most negative value. It holds until the next accepted start or rst.
- Undefined: illegal_lanes is tied to 0.
- Sequencing is identical in both cases.

Decomposition:
- Package simd_booth_pkg holds:
  - mode constants MODE_1X16=2'b00, MODE_2X8=2'b01, MODE_4X4=2'b10;
  - iteration counts 16/8/4;
  - the FSM state enum;
  - lane field offset constants.
- Sub-module booth_lane_step, parameterised by A_W and Q_W: combinational add/sub plus arithmetic shift of one lane. It is instantiated 1+2+4 times and muxed by the latched mode.

Test Plan:
- mode 00, mcand=16'h0007, mplier=16'hFFFD -> done at t+18, product=32'hFFFFFFEB (-21).
- mode 00, mcand=16'h8000, mplier=16'h8000 -> product=32'h40000000.
- mode 01, mcand=16'hFD05, mplier=16'h0AF9 -> p0=5*-7=16'hFFDD, p1=-3*10=16'hFFE2, done at t+10.
- mode 10, mcand=16'h7F32, mplier=16'h2F37 -> p0=2*7=8'h0E, p1=3*3=8'h09, p2=-1*-1=8'h01, p3=7*2=8'h0E, done at t+6.
- start held during RUN, and a start with mode=11 in IDLE -> both ignored; busy and state unaffected; a single done pulse results.
- rst asserted mid-RUN in mode 00 -> next cycle IDLE, acc_ld=0, done never pulses. A fresh start afterwards gives a correct result.
- BOOTH_OPCHECK_EN defined, mode 10, mcand=16'h8888 -> illegal_lanes=4'hF after INIT; in mode 00 the same operand gives 4'h0.
